// File: rtl/b16to1_tdm_mux.sv
// 16-to-1 time-division serializer: captures a parallel word and shifts it out one
// bit per valid/ready transfer together with the channel index of each bit.
//
// state | meaning
// IDLE  | waiting for start; valid/busy low, done may pulse for one cycle
// SEND  | frame in progress; current bit and its index presented on z0/b3_b0
module b16to1_tdm_mux #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] x15_x0,
  input  logic        start,
  input  logic        ready,
  output logic        z0,
  output logic [3:0]  b3_b0,
  output logic        valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [3:0] FIRST_IDX = MSB_FIRST ? 4'd15 : 4'd0;

  state_t      state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  index_step;
  logic        z0_d;
  logic [3:0]  b3_b0_d;
  logic        valid_d, busy_d, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= 16'h0000;
      index_q  <= FIRST_IDX;
      count_q  <= 4'd0;
      z0       <= 1'b0;
      b3_b0    <= 4'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      index_q  <= index_d;
      count_q  <= count_d;
      z0       <= z0_d;
      b3_b0    <= b3_b0_d;
      valid    <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    index_step = MSB_FIRST ? (index_q - 4'd1) : (index_q + 4'd1);
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    index_d  = index_q;
    count_d  = count_q;
    z0_d     = z0;
    b3_b0_d  = b3_b0;
    valid_d  = valid;
    busy_d   = busy;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = x15_x0;
          index_d  = FIRST_IDX;
          count_d  = 4'd0;
          state_d  = SEND;
          z0_d     = x15_x0[FIRST_IDX];
          b3_b0_d  = FIRST_IDX;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        // Outputs are registered, so the next bit is looked up one step ahead.
        if (ready) begin
          if (count_q == 4'd15) begin
            state_d = IDLE;
            z0_d    = 1'b0;
            b3_b0_d = 4'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            index_d = index_step;
            count_d = count_q + 4'd1;
            z0_d    = shadow_q[index_step];
            b3_b0_d = index_step;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
